// File: rtl/sys_defs.sv
// Shared system definitions: data width, branch queue sizing and the queue entry layout.
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

    localparam int DEPTH = 8;
    localparam int TAG_W = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic             resolved;
        logic [`XLEN-1:0] pc;
        logic             pred_dir;
        logic [`XLEN-1:0] pred_target;
        logic             act_dir;
        logic [`XLEN-1:0] act_target;
    } bq_entry_t;

endpackage

// File: rtl/branch_update_queue.sv
// In-order branch update queue: dual allocate, out-of-order resolve, dual in-order
// retire to the predictor, and whole-queue flush on the first mispredicting retire.
module branch_update_queue
    import sys_defs::*;
#(
    parameter int DEPTH = sys_defs::DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  alloc_valid,
    input  logic [1:0][`XLEN-1:0]       alloc_PC,
    input  logic [1:0]                  alloc_pred_dir,
    input  logic [1:0][`XLEN-1:0]       alloc_pred_target,
    output logic                        alloc_ready,
    output logic [1:0][TAG_W-1:0]       alloc_tag,
    input  logic [1:0]                  resolve_valid,
    input  logic [1:0][TAG_W-1:0]       resolve_tag,
    input  logic [1:0]                  resolve_dir,
    input  logic [1:0][`XLEN-1:0]       resolve_target,
    output logic [1:0]                  valid_update,
    output logic [1:0][`XLEN-1:0]       PC_update,
    output logic [1:0]                  direction_update,
    output logic [1:0][`XLEN-1:0]       target_update,
    output logic                        mispredict,
    output logic [`XLEN-1:0]            recovery_PC,
    output logic [TAG_W:0]              count
);

    typedef logic [TAG_W:0] ptr_t;

    localparam ptr_t             READY_MAX = ptr_t'(DEPTH - 2);
    localparam logic [TAG_W-1:0] ONE_T     = TAG_W'(1);

    ptr_t      head_q, head_d, tail_q, tail_d;
    bq_entry_t entries_q [DEPTH];
    bq_entry_t entries_d [DEPTH];

    logic [TAG_W-1:0] h0, h1;
    bq_entry_t        e0, e1;
    logic             ret0, ret1, mis0, mis1;
    logic [1:0]       alloc_en;

    assign h0 = head_q[TAG_W-1:0];
    assign h1 = h0 + ONE_T;
    assign e0 = entries_q[h0];
    assign e1 = entries_q[h1];

    // Slot 1 may only retire behind a correctly predicted slot 0.
    assign ret0 = e0.valid & e0.resolved;
    assign mis0 = ret0 & ((e0.act_dir != e0.pred_dir) |
                          (e0.act_dir & (e0.act_target != e0.pred_target)));
    assign ret1 = ret0 & ~mis0 & e1.valid & e1.resolved;
    assign mis1 = ret1 & ((e1.act_dir != e1.pred_dir) |
                          (e1.act_dir & (e1.act_target != e1.pred_target)));

    assign count        = tail_q - head_q;
    assign alloc_ready  = (count <= READY_MAX);
    assign alloc_tag[0] = tail_q[TAG_W-1:0];
    assign alloc_tag[1] = tail_q[TAG_W-1:0] + ONE_T;
    assign alloc_en[0]  = alloc_ready & alloc_valid[0];
    assign alloc_en[1]  = alloc_ready & alloc_valid[0] & alloc_valid[1];

    always_comb begin
        valid_update     = {ret1, ret0};
        PC_update        = '0;
        direction_update = '0;
        target_update    = '0;
        mispredict       = mis0 | mis1;
        recovery_PC      = '0;
        if (ret0) begin
            PC_update[0]        = e0.pc;
            direction_update[0] = e0.act_dir;
            target_update[0]    = e0.act_target;
        end
        if (ret1) begin
            PC_update[1]        = e1.pc;
            direction_update[1] = e1.act_dir;
            target_update[1]    = e1.act_target;
        end
        if (mis0) begin
            recovery_PC = e0.act_dir ? e0.act_target : e0.pc + `XLEN'(4);
        end else if (mis1) begin
            recovery_PC = e1.act_dir ? e1.act_target : e1.pc + `XLEN'(4);
        end
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (mispredict) begin
            // Flush: everything in flight is wrong-path, including this cycle's traffic.
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid    = 1'b0;
                entries_d[i].resolved = 1'b0;
            end
            head_d = tail_q;
        end else begin
            if (ret0) begin
                entries_d[h0].valid    = 1'b0;
                entries_d[h0].resolved = 1'b0;
            end
            if (ret1) begin
                entries_d[h1].valid    = 1'b0;
                entries_d[h1].resolved = 1'b0;
            end
            head_d = head_q + ptr_t'(ret0) + ptr_t'(ret1);
            for (int k = 0; k < 2; k++) begin
                if (resolve_valid[k] && entries_q[resolve_tag[k]].valid &&
                    !entries_q[resolve_tag[k]].resolved) begin
                    entries_d[resolve_tag[k]].resolved   = 1'b1;
                    entries_d[resolve_tag[k]].act_dir    = resolve_dir[k];
                    entries_d[resolve_tag[k]].act_target = resolve_target[k];
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (alloc_en[k]) begin
                    entries_d[alloc_tag[k]].valid       = 1'b1;
                    entries_d[alloc_tag[k]].resolved    = 1'b0;
                    entries_d[alloc_tag[k]].pc          = alloc_PC[k];
                    entries_d[alloc_tag[k]].pred_dir    = alloc_pred_dir[k];
                    entries_d[alloc_tag[k]].pred_target = alloc_pred_target[k];
                    entries_d[alloc_tag[k]].act_dir     = 1'b0;
                    entries_d[alloc_tag[k]].act_target  = '0;
                end
            end
            tail_d = tail_q + ptr_t'(alloc_en[0]) + ptr_t'(alloc_en[1]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid    <= 1'b0;
                entries_q[i].resolved <= 1'b0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed and randomized checks of branch_update_queue against a list-based queue model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_branch_update_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic                   clock;
    logic                   reset;
    logic [1:0]             alloc_valid;
    logic [1:0][`XLEN-1:0]  alloc_PC;
    logic [1:0]             alloc_pred_dir;
    logic [1:0][`XLEN-1:0]  alloc_pred_target;
    logic                   alloc_ready;
    logic [1:0][TAG_W-1:0]  alloc_tag;
    logic [1:0]             resolve_valid;
    logic [1:0][TAG_W-1:0]  resolve_tag;
    logic [1:0]             resolve_dir;
    logic [1:0][`XLEN-1:0]  resolve_target;
    logic [1:0]             valid_update;
    logic [1:0][`XLEN-1:0]  PC_update;
    logic [1:0]             direction_update;
    logic [1:0][`XLEN-1:0]  target_update;
    logic                   mispredict;
    logic [`XLEN-1:0]       recovery_PC;
    logic [TAG_W:0]         count;

    branch_update_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_PC(alloc_PC),
        .alloc_pred_dir(alloc_pred_dir), .alloc_pred_target(alloc_pred_target),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_dir(resolve_dir), .resolve_target(resolve_target),
        .valid_update(valid_update), .PC_update(PC_update),
        .direction_update(direction_update), .target_update(target_update),
        .mispredict(mispredict), .recovery_PC(recovery_PC), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic        pd;
        logic [31:0] pt;
        logic        res;
        logic        ad;
        logic [31:0] at;
    } ment_t;

    ment_t mq[$];
    int    m_tail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alloc_valid = '0; alloc_PC = '0; alloc_pred_dir = '0; alloc_pred_target = '0;
        resolve_valid = '0; resolve_tag = '0; resolve_dir = '0; resolve_target = '0;
    endtask

    task automatic set_alloc(input int s, input logic [31:0] pc, input logic pd, input logic [31:0] pt);
        alloc_valid[s] = 1'b1; alloc_PC[s] = pc; alloc_pred_dir[s] = pd; alloc_pred_target[s] = pt;
    endtask

    task automatic set_res(input int s, input logic [TAG_W-1:0] tg, input logic d, input logic [31:0] t);
        resolve_valid[s] = 1'b1; resolve_tag[s] = tg; resolve_dir[s] = d; resolve_target[s] = t;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic bit m_mis(input ment_t e);
        return (e.ad != e.pd) || (e.ad && (e.at != e.pt));
    endfunction

    function automatic logic [31:0] m_rec(input ment_t e);
        return e.ad ? e.at : e.pc + 32'd4;
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        do_reset();

        // reset state
        chk("rst_count", 64'(count), 0);
        chk("rst_ready", 64'(alloc_ready), 1);
        chk("rst_tag0", 64'(alloc_tag[0]), 0);
        chk("rst_tag1", 64'(alloc_tag[1]), 1);
        chk("rst_vu", 64'(valid_update), 0);
        chk("rst_mis", 64'(mispredict), 0);
        chk("rst_rec", 64'(recovery_PC), 0);

        // two correctly predicted branches retire together
        set_alloc(0, 32'h100, 1'b0, 32'h0);
        set_alloc(1, 32'h104, 1'b0, 32'h0);
        tick(); idle();
        chk("d1_count", 64'(count), 2);
        chk("d1_tag0", 64'(alloc_tag[0]), 2);
        set_res(0, 3'd0, 1'b0, 32'h0);
        set_res(1, 3'd1, 1'b0, 32'h0);
        chk("d1_noupd", 64'(valid_update), 0);
        tick(); idle();
        chk("d1_vu", 64'(valid_update), 2'b11);
        chk("d1_pc0", 64'(PC_update[0]), 32'h100);
        chk("d1_pc1", 64'(PC_update[1]), 32'h104);
        chk("d1_mis", 64'(mispredict), 0);
        tick();
        chk("d1_count_after", 64'(count), 0);
        chk("d1_vu_after", 64'(valid_update), 0);

        // out-of-order resolution, in-order retire
        do_reset();
        set_alloc(0, 32'h10, 1'b0, 32'h0);
        set_alloc(1, 32'h14, 1'b0, 32'h0);
        tick(); idle();
        set_alloc(0, 32'h18, 1'b0, 32'h0);
        tick(); idle();
        set_res(0, 3'd2, 1'b0, 32'h0);
        tick(); idle();
        chk("d2_head_wait", 64'(valid_update), 0);
        set_res(0, 3'd0, 1'b0, 32'h0);
        tick(); idle();
        chk("d2_vu0", 64'(valid_update), 2'b01);
        chk("d2_pc0", 64'(PC_update[0]), 32'h10);
        set_res(0, 3'd1, 1'b0, 32'h0);
        tick(); idle();
        chk("d2_vu12", 64'(valid_update), 2'b11);
        chk("d2_pc1", 64'(PC_update[0]), 32'h14);
        chk("d2_pc2", 64'(PC_update[1]), 32'h18);
        tick();
        chk("d2_count", 64'(count), 0);

        // mispredict on the head flushes the queue and drops the same-cycle alloc
        do_reset();
        set_alloc(0, 32'h200, 1'b0, 32'h0);
        set_alloc(1, 32'h204, 1'b0, 32'h0);
        tick(); idle();
        set_res(0, 3'd0, 1'b1, 32'h400);
        set_res(1, 3'd1, 1'b0, 32'h0);
        tick(); idle();
        chk("d3_vu", 64'(valid_update), 2'b01);
        chk("d3_mis", 64'(mispredict), 1);
        chk("d3_rec", 64'(recovery_PC), 32'h400);
        chk("d3_dir", 64'(direction_update), 2'b01);
        chk("d3_tgt", 64'(target_update[0]), 32'h400);
        set_alloc(0, 32'h300, 1'b0, 32'h0);
        tick(); idle();
        chk("d3_count", 64'(count), 0);
        chk("d3_mis_after", 64'(mispredict), 0);
        chk("d3_tail_tag", 64'(alloc_tag[0]), 2);
        chk("d3_vu_after", 64'(valid_update), 0);

        // fill, back-pressure, drain, tag wrap
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(0, 32'h1000 + 32'(i * 8), 1'b0, 32'h0);
            set_alloc(1, 32'h1004 + 32'(i * 8), 1'b0, 32'h0);
            tick(); idle();
            chk("d4_fill_ready", 64'(alloc_ready), 1);
        end
        set_alloc(0, 32'h1018, 1'b0, 32'h0);
        tick(); idle();
        chk("d4_count7", 64'(count), 7);
        chk("d4_ready7", 64'(alloc_ready), 0);
        set_alloc(0, 32'h2000, 1'b0, 32'h0);
        set_alloc(1, 32'h2004, 1'b0, 32'h0);
        tick(); idle();
        chk("d4_ignored_count", 64'(count), 7);
        chk("d4_ignored_tag", 64'(alloc_tag[0]), 7);
        set_res(0, 3'd0, 1'b0, 32'h0);
        set_res(1, 3'd1, 1'b0, 32'h0);
        tick(); idle();
        chk("d4_drain_vu", 64'(valid_update), 2'b11);
        tick();
        chk("d4_count5", 64'(count), 5);
        chk("d4_ready5", 64'(alloc_ready), 1);
        chk("d4_wrap_tag0", 64'(alloc_tag[0]), 7);
        chk("d4_wrap_tag1", 64'(alloc_tag[1]), 0);
        set_alloc(0, 32'h3000, 1'b0, 32'h0);
        set_alloc(1, 32'h3004, 1'b0, 32'h0);
        tick(); idle();
        chk("d4_count_wrap", 64'(count), 7);
        chk("d4_tag_after_wrap", 64'(alloc_tag[0]), 1);

        // ignored resolves, then reset with live entries
        do_reset();
        set_alloc(0, 32'h500, 1'b0, 32'h0); set_alloc(1, 32'h504, 1'b0, 32'h0);
        tick(); idle();
        set_alloc(0, 32'h508, 1'b0, 32'h0); set_alloc(1, 32'h50c, 1'b0, 32'h0);
        tick(); idle();
        set_alloc(0, 32'h510, 1'b0, 32'h0);
        tick(); idle();
        set_res(0, 3'd6, 1'b1, 32'h55);
        tick(); idle();
        chk("d5_invalid_count", 64'(count), 5);
        chk("d5_invalid_vu", 64'(valid_update), 0);
        set_res(0, 3'd1, 1'b0, 32'h0);
        tick(); idle();
        set_res(0, 3'd1, 1'b1, 32'h999);
        tick(); idle();
        chk("d5_double_vu", 64'(valid_update), 0);
        set_res(0, 3'd0, 1'b0, 32'h0);
        tick(); idle();
        chk("d5_retire_vu", 64'(valid_update), 2'b11);
        chk("d5_retire_dir", 64'(direction_update), 2'b00);
        chk("d5_retire_tgt1", 64'(target_update[1]), 0);
        chk("d5_retire_mis", 64'(mispredict), 0);
        tick();
        chk("d5_count3", 64'(count), 3);
        set_alloc(0, 32'h514, 1'b0, 32'h0); set_alloc(1, 32'h518, 1'b0, 32'h0);
        tick(); idle();
        chk("d5_count5", 64'(count), 5);
        set_res(0, 3'd2, 1'b0, 32'h0);
        reset = 1'b1;
        tick(); idle();
        reset = 1'b0;
        chk("d5_rst_count", 64'(count), 0);
        chk("d5_rst_vu", 64'(valid_update), 0);
        chk("d5_rst_tag0", 64'(alloc_tag[0]), 0);
        chk("d5_rst_ready", 64'(alloc_ready), 1);
        tick();
        chk("d5_rst_vu_later", 64'(valid_update), 0);

        // randomized traffic against the list model
        mq.delete();
        m_tail = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int          nret;
            bit          emis;
            logic [31:0] erec;
            int          nalloc;
            int          pre_size;
            bit          do_rst;
            int          cand[$];
            ment_t       e;

            nret = 0; emis = 1'b0; erec = '0;
            if (mq.size() > 0 && mq[0].res) begin
                nret = 1;
                if (m_mis(mq[0])) begin
                    emis = 1'b1; erec = m_rec(mq[0]);
                end else if (mq.size() > 1 && mq[1].res) begin
                    nret = 2;
                    if (m_mis(mq[1])) begin
                        emis = 1'b1; erec = m_rec(mq[1]);
                    end
                end
            end
            chk("r_vu", 64'(valid_update), (nret == 0) ? 0 : (nret == 1) ? 1 : 3);
            for (int s = 0; s < nret; s++) begin
                chk("r_pc", 64'(PC_update[s]), 64'(mq[s].pc));
                chk("r_dir", 64'(direction_update[s]), 64'(mq[s].ad));
                chk("r_tgt", 64'(target_update[s]), 64'(mq[s].at));
            end
            chk("r_mis", 64'(mispredict), 64'(emis));
            chk("r_rec", 64'(recovery_PC), 64'(erec));
            chk("r_count", 64'(count), 64'(mq.size()));
            chk("r_ready", 64'(alloc_ready), (mq.size() <= DEPTH - 2) ? 1 : 0);
            chk("r_tag0", 64'(alloc_tag[0]), 64'(m_tail % DEPTH));
            chk("r_tag1", 64'(alloc_tag[1]), 64'((m_tail + 1) % DEPTH));
            if (mq.size() == 0) chk("r_empty_pc", 64'(PC_update), 0);

            idle();
            nalloc = $urandom_range(0, 2);
            for (int s = 0; s < nalloc; s++) begin
                set_alloc(s, $urandom() & 32'hffff_fffc, 1'($urandom_range(0, 1)),
                          $urandom() & 32'hffff_fffc);
            end
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int          tg;
                    logic        d;
                    logic [31:0] t;
                    cand.delete();
                    foreach (mq[i]) if (!mq[i].res) cand.push_back(i);
                    if (cand.size() > 0 && $urandom_range(0, 4) != 0) begin
                        int pick;
                        pick = cand[$urandom_range(0, cand.size() - 1)];
                        tg = mq[pick].tag;
                        if ($urandom_range(0, 5) != 0) begin
                            d = mq[pick].pd; t = mq[pick].pt;
                        end else begin
                            d = 1'($urandom_range(0, 1)); t = $urandom() & 32'hffff_fffc;
                        end
                    end else begin
                        tg = $urandom_range(0, DEPTH - 1);
                        d = 1'($urandom_range(0, 1)); t = $urandom() & 32'hffff_fffc;
                    end
                    if (!(s == 1 && resolve_valid[0] && int'(resolve_tag[0]) == tg))
                        set_res(s, TAG_W'(tg), d, t);
                end
            end
            do_rst = ($urandom_range(0, 199) == 0);
            reset = do_rst;
            pre_size = mq.size();
            tick();
            reset = 1'b0;

            if (do_rst) begin
                mq.delete();
                m_tail = 0;
            end else if (emis) begin
                mq.delete();
            end else begin
                for (int s = 0; s < nret; s++) void'(mq.pop_front());
                for (int s = 0; s < 2; s++) begin
                    if (resolve_valid[s]) begin
                        foreach (mq[i]) begin
                            if (mq[i].tag == int'(resolve_tag[s]) && !mq[i].res) begin
                                mq[i].res = 1'b1;
                                mq[i].ad  = resolve_dir[s];
                                mq[i].at  = resolve_target[s];
                            end
                        end
                    end
                end
                if (pre_size <= DEPTH - 2) begin
                    for (int s = 0; s < nalloc; s++) begin
                        e.tag = m_tail % DEPTH;
                        e.pc  = alloc_PC[s];
                        e.pd  = alloc_pred_dir[s];
                        e.pt  = alloc_pred_target[s];
                        e.res = 1'b0;
                        e.ad  = 1'b0;
                        e.at  = '0;
                        mq.push_back(e);
                        m_tail++;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
